// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the memory stage: the access FSM state,
// the load result-select code and the MEM/WB register layout.
package pipeline_pkg;

   localparam int XLEN = 32;

   // ResultSrc code that selects the data-memory read value in writeback
   localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_t;

   // MEM/WB register contents; an all-zero value is a bubble
   typedef struct packed {
      logic            reg_write;
      logic [1:0]      result_src;
      logic [XLEN-1:0] alu_result;
      logic [XLEN-1:0] read_data;
      logic [4:0]      rd;
      logic [XLEN-1:0] pc_plus;
   } mw_reg_t;

endpackage

// File: rtl/byte_lane_unit.sv
// Byte-lane steering for data-memory accesses: forms byte enables and the
// replicated store data, and extracts the loaded byte.
// With BYTE_ACCESS_EN undefined every access is a full-word access and the
// size/lane inputs are not used.
import pipeline_pkg::*;

module byte_lane_unit (
   input  logic [1:0]      addr_lsb,
   input  logic            st_byte,
   input  logic            ld_byte,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rdata,
   output logic [3:0]      be,
   output logic [XLEN-1:0] wdata_out,
   output logic [XLEN-1:0] ld_data
);

`ifdef BYTE_ACCESS_EN
   // Steer store lanes and pick the addressed load byte
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
      be        = 4'hF;
      wdata_out = wdata;
      ld_data   = rdata;
      if (st_byte) begin
         be        = 4'b0001 << addr_lsb;
         wdata_out = {(XLEN/8){wdata[7:0]}};
      end
      if (ld_byte) begin
         case (addr_lsb)
            2'd0:    ld_data = {{(XLEN-8){1'b0}}, rdata[7:0]};
            2'd1:    ld_data = {{(XLEN-8){1'b0}}, rdata[15:8]};
            2'd2:    ld_data = {{(XLEN-8){1'b0}}, rdata[23:16]};
            default: ld_data = {{(XLEN-8){1'b0}}, rdata[31:24]};
         endcase
      end
   end
`else
   logic unused_lane_inputs;

   // Word-only build: pass data straight through
   always_comb begin
      be                 = 4'hF;
      wdata_out          = wdata;
      ld_data            = rdata;
      unused_lane_inputs = ^{addr_lsb, st_byte, ld_byte};
   end
`endif

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: issues the EX/MEM load or store over a valid/ready
// handshake, stalls upstream while memory is busy, times out a dead memory
// with a sticky error flag, and forms the MEM/WB register.
// Optional build macro: BYTE_ACCESS_EN enables byte loads/stores.
import pipeline_pkg::*;

module mem_access_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  RegWriteM,
   input  logic                  MemWriteM,
   input  logic                  StSrcM,
   input  logic                  LdSrcM,
   input  logic [1:0]            ResultSrcM,
   input  logic [DATA_WIDTH-1:0] ALUResultM,
   input  logic [DATA_WIDTH-1:0] WriteDataM,
   input  logic [DATA_WIDTH-1:0] PC_PlusM,
   input  logic [4:0]            RdM,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_be,
   input  logic                  mem_ready,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  StallM,
   output logic                  MemErr,
   output logic                  RegWriteW,
   output logic [1:0]            ResultSrcW,
   output logic [DATA_WIDTH-1:0] ALUResultW,
   output logic [DATA_WIDTH-1:0] ReadDataW,
   output logic [4:0]            RdW,
   output logic [DATA_WIDTH-1:0] PC_PlusW
);

   // Last WAIT-cycle count before the access is abandoned
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   mem_state_t      state_q;
   logic [7:0]      wait_cnt_q;
   logic            err_q;
   mw_reg_t         w_q;

   logic            access;
   logic            is_load;
   logic            in_wait;
   logic            timeout_hit;
   logic [XLEN-1:0] ld_data;

   byte_lane_unit u_lanes (
      .addr_lsb  (ALUResultM[1:0]),
      .st_byte   (StSrcM),
      .ld_byte   (LdSrcM),
      .wdata     (WriteDataM),
      .rdata     (mem_rdata),
      .be        (mem_be),
      .wdata_out (mem_wdata),
      .ld_data   (ld_data)
   );

   // Handshake and stall decode; request is killed by reset with no clock
   always_comb begin
      is_load     = (ResultSrcM == RESULT_SRC_MEM);
      access      = MemWriteM | is_load;
      in_wait     = (state_q == WAIT);
      mem_req     = rst_n & (in_wait | access);
      mem_we      = mem_req & MemWriteM;
      mem_addr    = {ALUResultM[DATA_WIDTH-1:2], 2'b00};
      timeout_hit = in_wait & ~mem_ready & (wait_cnt_q == TIMEOUT_LAST);
      StallM      = mem_req & ~mem_ready & ~timeout_hit;
   end

   // Access FSM, wait counter and sticky timeout flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         case (state_q)
            IDLE: begin
               if (access && !mem_ready) begin
                  state_q    <= WAIT;
                  wait_cnt_q <= '0;
               end
            end
            default: begin
               if (mem_ready) begin
                  state_q <= IDLE;
               end else if (timeout_hit) begin
                  state_q <= IDLE;
                  err_q   <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 8'd1;
               end
            end
         endcase
      end
   end

   // MEM/WB register: bubble while stalled or on a timed-out access
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_q <= '0;
      end else if (StallM || timeout_hit) begin
         w_q <= '0;
      end else begin
         w_q.reg_write  <= RegWriteM;
         w_q.result_src <= ResultSrcM;
         w_q.alu_result <= ALUResultM;
         w_q.read_data  <= is_load ? ld_data : '0;
         w_q.rd         <= RdM;
         w_q.pc_plus    <= PC_PlusM;
      end
   end

   assign MemErr     = err_q;
   assign RegWriteW  = w_q.reg_write;
   assign ResultSrcW = w_q.result_src;
   assign ALUResultW = w_q.alu_result;
   assign ReadDataW  = w_q.read_data;
   assign RdW        = w_q.rd;
   assign PC_PlusW   = w_q.pc_plus;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus random
// instructions against a transaction-level model of the stage.
module tb_mem_access_stage;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        RegWriteM, MemWriteM, StSrcM, LdSrcM;
   logic [1:0]  ResultSrcM;
   logic [31:0] ALUResultM, WriteDataM, PC_PlusM;
   logic [4:0]  RdM;
   logic        mem_req, mem_we, mem_ready, StallM, MemErr;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        RegWriteW;
   logic [1:0]  ResultSrcW;
   logic [31:0] ALUResultW, ReadDataW, PC_PlusW;
   logic [4:0]  RdW;

   int checks = 0;
   int errors = 0;
   bit exp_err = 1'b0;

   mem_access_stage #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .StSrcM(StSrcM), .LdSrcM(LdSrcM),
      .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .PC_PlusM(PC_PlusM), .RdM(RdM),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .StallM(StallM), .MemErr(MemErr),
      .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
      .ReadDataW(ReadDataW), .RdW(RdW), .PC_PlusW(PC_PlusW)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [103:0] w_bundle();
      return {RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PC_PlusW};
   endfunction

   // Reference: value written to the W read-data field for a completed access
   function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] addr,
                                            input logic ldb, input logic [1:0] rsrc);
      if (rsrc != 2'b01) return 32'h0;
`ifdef BYTE_ACCESS_EN
      if (ldb) return (rdata >> (8 * int'(addr[1:0]))) & 32'hFF;
`endif
      return rdata;
   endfunction

   function automatic logic [3:0] ref_be(input logic [31:0] addr, input logic stb);
`ifdef BYTE_ACCESS_EN
      if (stb) return 4'(1 << int'(addr[1:0]));
`endif
      return 4'hF;
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [31:0] wd, input logic stb);
`ifdef BYTE_ACCESS_EN
      if (stb) return {4{wd[7:0]}};
`endif
      return wd;
   endfunction

   task automatic set_m(input logic rw, input logic mw, input logic stb, input logic ldb,
                        input logic [1:0] rs, input logic [31:0] alu, input logic [31:0] wd,
                        input logic [4:0] rd);
      RegWriteM  = rw;  MemWriteM = mw; StSrcM = stb; LdSrcM = ldb;
      ResultSrcM = rs;  ALUResultM = alu; WriteDataM = wd; RdM = rd;
      PC_PlusM   = $urandom;
   endtask

   // Present the current M instruction (called just after a negedge); memory
   // answers after n refused cycles. Model: stall for min(n, TO) cycles; if
   // n > TO the access is abandoned as a bubble and MemErr becomes sticky.
   task automatic run_instr(input int n, input logic [31:0] rdata);
      bit acc = MemWriteM | (ResultSrcM == 2'b01);
      bit to  = acc && (n > TO);
      bit done = 1'b0;
      bit exp_stall;
      int idx = 0;
      int writes = 0;
      while (!done && idx <= TO + 2) begin
         mem_ready = acc ? (idx == n) : 1'($urandom_range(0, 1));
         mem_rdata = rdata;
         #1;
         exp_stall = acc && (idx < n) && (idx < TO);
         check("mem_req", mem_req, acc);
         check("StallM", StallM, exp_stall);
         if (acc) begin
            check("mem_addr", mem_addr, {ALUResultM[31:2], 2'b00});
            check("mem_we", mem_we, MemWriteM);
            if (MemWriteM) begin
               check("mem_be", mem_be, ref_be(ALUResultM, StSrcM));
               check("mem_wdata", mem_wdata, ref_wdata(WriteDataM, StSrcM));
            end
            if (mem_req && mem_we && mem_ready) writes++;
         end
         @(posedge clk);
         #1;
         if (exp_stall) begin
            check("bubble", w_bundle(), 104'h0);
         end else begin
            done = 1'b1;
            if (to) begin
               exp_err = 1'b1;
               check("timeout_bubble", w_bundle(), 104'h0);
            end else begin
               check("RegWriteW", RegWriteW, RegWriteM);
               check("ResultSrcW", ResultSrcW, ResultSrcM);
               check("ALUResultW", ALUResultW, ALUResultM);
               check("ReadDataW", ReadDataW, ref_load(rdata, ALUResultM, LdSrcM, ResultSrcM));
               check("RdW", RdW, RdM);
               check("PC_PlusW", PC_PlusW, PC_PlusM);
            end
         end
         check("MemErr", MemErr, exp_err);
         idx++;
         @(negedge clk);
      end
      check("retired", done, 1'b1);
      if (MemWriteM) check("store_transfers", writes, to ? 0 : 1);
   endtask

   initial begin
      rst_n     = 1'b0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      set_m(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h40, 32'h1, 5'd1);
      #2;
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_StallM", StallM, 1'b0);
      check("rst_MemErr", MemErr, 1'b0);
      check("rst_W", w_bundle(), 104'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // ADD x5: straight through in one cycle
      set_m(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h10, 32'h0, 5'd5);
      run_instr(0, 32'h0);
      // SW 0x100 with three refused cycles
      set_m(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h100, 32'hDEADBEEF, 5'd0);
      run_instr(3, 32'h0);
      // LW 0x200, zero wait
      set_m(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 32'h200, 32'h0, 5'd7);
      run_instr(0, 32'h12345678);
`ifdef BYTE_ACCESS_EN
      set_m(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 32'h103, 32'h000000AB, 5'd0);
      run_instr(0, 32'h0);
      set_m(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 32'h101, 32'h0, 5'd9);
      run_instr(1, 32'h11223344);
`endif
      // Ready arriving exactly on the timeout cycle completes normally
      set_m(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 32'h300, 32'h0, 5'd3);
      run_instr(TO, 32'hCAFEF00D);
      // Memory never answers: timeout
      set_m(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 32'h304, 32'h0, 5'd4);
      run_instr(1000, 32'h0);
      // Following instruction proceeds with MemErr still set
      set_m(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 32'h55, 32'h0, 5'd6);
      run_instr(0, 32'h0);

      // Reset in the middle of a WAIT
      set_m(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h400, 32'h99, 5'd0);
      mem_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      check("pre_rst_stall", StallM, 1'b1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_mem_req", mem_req, 1'b0);
      check("mid_rst_StallM", StallM, 1'b0);
      check("mid_rst_W", w_bundle(), 104'h0);
      check("mid_rst_MemErr", MemErr, 1'b0);
      exp_err = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      set_m(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h77, 32'h0, 5'd11);
      run_instr(0, 32'h0);

      // Random instruction mix with random memory latency
      for (int i = 0; i < 80; i++) begin
         int kind = $urandom_range(0, 2);
         int n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, TO + 2);
         case (kind)
            0: set_m(1'($urandom), 1'b0, 1'($urandom), 1'($urandom),
                     ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10, $urandom, $urandom, 5'($urandom));
            1: set_m(1'b1, 1'b0, 1'b0, 1'($urandom), 2'b01, $urandom, $urandom, 5'($urandom));
            default: set_m(1'b0, 1'b1, 1'($urandom), 1'b0, 2'b00, $urandom, $urandom, 5'($urandom));
         endcase
         run_instr(n, $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory stage of the five-stage pipeline. It consumes the EX/MEM register outputs and performs the data-memory load or store over a valid/ready handshake, stalling the pipeline while memory is busy. It also forms the MEM/WB pipeline register that feeds writeback. With a zero-wait memory it adds exactly one register stage.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath and address width
- TIMEOUT_CYCLES, 255, maximum WAIT cycles before `MemErr` is raised; fits in 8 bits

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- RegWriteM, MemWriteM, StSrcM, LdSrcM  in  1 each  control from EX/MEM; StSrc/LdSrc = byte store/load
- ResultSrcM  in  2  2'b01 = load
- ALUResultM, WriteDataM, PC_PlusM  in  DATA_WIDTH  address/result, store data, PC+4
- RdM  in  5  destination register
- mem_req  out  1  access request
- mem_we  out  1  write enable
- mem_addr  out  DATA_WIDTH  word address
- mem_wdata  out  DATA_WIDTH  write data
- mem_be  out  4  byte enables
- mem_ready  in  1  access complete this cycle
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ready
- StallM  out  1  freeze PC, F/D, D/E and E/M registers
- MemErr  out  1  sticky timeout flag
- RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PC_PlusW  out  same widths as M  MEM/WB register

## Operation
- Access = MemWriteM | (ResultSrcM == 2'b01). Non-access instructions pass straight to the W register.
- FSM has two states, IDLE and WAIT.
- IDLE, access present: `mem_req` is driven combinationally high.
  - `mem_ready` high the same cycle: access completes, W is loaded on this edge, state stays IDLE.
  - `mem_ready` low: go to WAIT; `StallM` = 1.
- WAIT: `mem_req`, `mem_addr`, `mem_we`, `mem_wdata` and `mem_be` are held, and `StallM` = 1.
  - On `mem_ready`: capture data, load W, return to IDLE.
  - Upstream holds the M inputs stable while `StallM` is high.
- Each store issues exactly one transfer, whatever the stall length.
- While `StallM` = 1, each edge loads a bubble into W: RegWriteW = 0, other W fields 0.
- Address: mem_addr = {ALUResultM[31:2], 2'b00}.
- Word access: mem_be = 4'hF; mem_wdata = WriteDataM; ReadDataW = mem_rdata.
- Timeout:
  - An 8-bit counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES, `MemErr` is set (sticky until reset) and the FSM returns to IDLE.
  - The load/store is then retired as a bubble: RegWriteW = 0.

## Timing
- Reset (async assert, sync release): state IDLE, counter 0, mem_req 0, StallM 0, MemErr 0, all W outputs 0.
- Non-access and zero-wait access: 1 cycle M→W.
- Access with N wait cycles: StallM is high for N cycles; W updates on the edge where mem_ready = 1.
- mem_ready is ignored when mem_req = 0.
- Reset asserted in WAIT aborts the access immediately; mem_req drops asynchronously.
- Timeout and mem_ready in the same cycle: mem_ready wins and the access completes normally.

## Configuration
- BYTE_ACCESS_EN defined:
  - StSrcM = 1 gives mem_wdata = {4{WriteDataM[7:0]}} and mem_be = 4'b0001 << ALUResultM[1:0].
  - LdSrcM = 1 gives ReadDataW = zero-extended byte lane ALUResultM[1:0] of mem_rdata.
- BYTE_ACCESS_EN undefined: StSrcM and LdSrcM are ignored; all accesses are word accesses.

## Structure
- Shared package `pipeline_pkg`:
  - `mem_state_t` enum {IDLE, WAIT}
  - RESULT_SRC_MEM = 2'b01
  - `mw_reg_t` packed struct holding the W fields
- One sub-module, `byte_lane_unit` (combinational): given address LSBs, size and data, it produces mem_be, mem_wdata and the extracted load data.

## Test plan
- ADD, RdM=5, ALUResultM=0x10, RegWriteM=1 → next cycle RdW=5, ALUResultW=0x10, StallM never high.
- SW to 0x100, data 0xDEADBEEF, mem_ready held low 3 cycles → StallM high 3 cycles, exactly one write with mem_be=4'hF, W receives 3 bubbles, then the store retires.
- LW from 0x200, mem_rdata=0x12345678 with zero wait → ReadDataW=0x12345678 and ResultSrcW=01 one cycle later.
- BYTE_ACCESS_EN, SB to 0x103 with data 0xAB → mem_be=4'b1000, mem_wdata=0xABABABAB; LB from 0x101 with rdata 0x11223344 → ReadDataW=0x00000033.
- mem_ready never asserted, TIMEOUT_CYCLES=4 → MemErr set after 4 WAIT cycles, StallM drops, RegWriteW=0.
- rst_n pulsed low mid-WAIT → mem_req, StallM and all W outputs 0 immediately; the next instruction proceeds normally.
